// File: rtl/sram_arbiter.sv
// Two-port (CPU / loader) round-robin arbiter and fixed-timing external SRAM access sequencer.
// Latency: request sampled in IDLE at cycle 0 -> owner ack in cycle WAIT_CYCLES+2; 1 IDLE cycle between grants.
// Backpressure: requesters hold req level until their ack pulse; the CPU sees cpu_stall meanwhile.
module sram_arbiter #(
  parameter int AW          = 10,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_out,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_in,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          busy
);

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state;
  logic          last_grant_ld;
  logic          owner_ld;
  logic          xfer_we;
  logic [CW-1:0] cnt;
  logic          grant_ld;
  req_t          cpu_r;
  req_t          ld_r;
  req_t          sel_r;

  // On a tie the port that did not win last time gets the grant.
  assign grant_ld  = ld_req & (~cpu_req | ~last_grant_ld);
  assign cpu_r     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ld_r      = '{we: ld_we, addr: ld_addr, wdata: ld_wdata};
  assign sel_r     = grant_ld ? ld_r : cpu_r;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != IDLE);

  // Strobes are registered together with the state so they switch on the state boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant_ld <= 1'b1;
      owner_ld      <= 1'b0;
      xfer_we       <= 1'b0;
      cnt           <= '0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      cpu_rdata     <= '0;
      ld_rdata      <= '0;
      cpu_ack       <= 1'b0;
      ld_ack        <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || ld_req) begin
            owner_ld    <= grant_ld;
            xfer_we     <= sel_r.we;
            sram_addr   <= sel_r.addr;
            sram_dq_out <= sel_r.wdata;
            sram_dq_oe  <= sel_r.we;
            sram_ce_n   <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          cnt       <= '0;
          sram_we_n <= ~xfer_we;
          sram_oe_n <= xfer_we;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            if (!xfer_we) begin
              if (owner_ld) ld_rdata  <= sram_dq_in;
              else          cpu_rdata <= sram_dq_in;
            end
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_dq_oe    <= 1'b0;
            ld_ack        <= owner_ld;
            cpu_ack       <= ~owner_ld;
            last_grant_ld <= owner_ld;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
